// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Redirect priority is EX branch > ID illop > stall > interrupt entry > ID jump > sequential.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
   parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_br_target,
   input  logic        id_jump,
   input  logic [31:0] id_jump_target,
   input  logic        id_illop,
   input  logic        irq,
   input  logic [31:0] instr_in,
   output logic [31:0] pc,
   output logic [31:0] IF2ID_PC_out,
   output logic [31:0] IF2ID_Instr_out,
   output logic        IF2ID_irq_out,
   output logic        flush_ID2EX,
   output logic        irq_pending
);

   typedef enum logic [2:0] {
      SEL_BRANCH,
      SEL_ILLOP,
      SEL_STALL,
      SEL_IRQ,
      SEL_JUMP,
      SEL_SEQ
   } sel_t;

   sel_t        sel;
   logic [31:0] pc_seq;
   logic [31:0] pc_next;

   // Sequential increment stays inside the current mode: bit 31 is never carried into.
   assign pc_seq      = {pc[31], pc[30:0] + 31'd4};
   assign flush_ID2EX = ex_br_taken | id_illop;

   always_comb begin
      sel = SEL_SEQ;
      if (ex_br_taken)
         sel = SEL_BRANCH;
      else if (id_illop)
         sel = SEL_ILLOP;
      else if (stall)
         sel = SEL_STALL;
      else if (irq_pending && !pc[31])
         sel = SEL_IRQ;
      else if (id_jump)
         sel = SEL_JUMP;
   end

   always_comb begin
      pc_next = pc_seq;
      case (sel)
         // A branch cannot change privilege: keep the current mode bit.
         SEL_BRANCH: pc_next = {pc[31], ex_br_target[30:0]};
         SEL_ILLOP:  pc_next = ILLOP_ADDR;
         SEL_STALL:  pc_next = pc;
         SEL_IRQ:    pc_next = XADR_ADDR;
         SEL_JUMP:   pc_next = id_jump_target;
         default:    pc_next = pc_seq;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc              <= RESET_PC;
         IF2ID_PC_out    <= RESET_PC;
         IF2ID_Instr_out <= 32'h0;
         IF2ID_irq_out   <= 1'b0;
         irq_pending     <= 1'b0;
      end else begin
         pc <= pc_next;
         if (sel != SEL_STALL) begin
            IF2ID_PC_out    <= pc_seq;
            IF2ID_Instr_out <= (sel == SEL_SEQ) ? instr_in : 32'h0;
            IF2ID_irq_out   <= (sel == SEL_IRQ);
         end
         // A still-asserted request re-arms pending on the same edge that takes entry.
         if (irq)
            irq_pending <= 1'b1;
         else if (sel == SEL_IRQ)
            irq_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory is modelled as instr = ~pc.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        ex_br_taken;
   logic [31:0] ex_br_target;
   logic        id_jump;
   logic [31:0] id_jump_target;
   logic        id_illop;
   logic        irq;
   logic [31:0] instr_in;
   logic [31:0] pc;
   logic [31:0] IF2ID_PC_out;
   logic [31:0] IF2ID_Instr_out;
   logic        IF2ID_irq_out;
   logic        flush_ID2EX;
   logic        irq_pending;

   int n_checks = 0;
   int n_fail   = 0;

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .ex_br_taken     (ex_br_taken),
      .ex_br_target    (ex_br_target),
      .id_jump         (id_jump),
      .id_jump_target  (id_jump_target),
      .id_illop        (id_illop),
      .irq             (irq),
      .instr_in        (instr_in),
      .pc              (pc),
      .IF2ID_PC_out    (IF2ID_PC_out),
      .IF2ID_Instr_out (IF2ID_Instr_out),
      .IF2ID_irq_out   (IF2ID_irq_out),
      .flush_ID2EX     (flush_ID2EX),
      .irq_pending     (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instr_in = ~pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcout);
      check({tag, "_pc"}, pc, e_pc);
      check({tag, "_instr"}, IF2ID_Instr_out, e_instr);
      check({tag, "_pcout"}, IF2ID_PC_out, e_pcout);
   endtask

   task automatic do_jump(input logic [31:0] target);
      id_jump = 1'b1;
      id_jump_target = target;
      step();
      id_jump = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; ex_br_taken = 1'b0; ex_br_target = 32'h0;
      id_jump = 1'b0; id_jump_target = 32'h0; id_illop = 1'b0; irq = 1'b0;
      step(); step();
      check_if("reset", 32'h8000_0000, 32'h0, 32'h8000_0000);
      check("reset_irq_out", {31'h0, IF2ID_irq_out}, 32'h0);
      check("reset_pending", {31'h0, irq_pending}, 32'h0);
      check("reset_flush", {31'h0, flush_ID2EX}, 32'h0);
      reset = 1'b0;

      // sequential fetch
      step(); check_if("seq1", 32'h8000_0004, 32'h7FFF_FFFF, 32'h8000_0004);
      step(); check_if("seq2", 32'h8000_0008, 32'h7FFF_FFFB, 32'h8000_0008);

      // jump bubble then stall at 0x100
      do_jump(32'h0000_0100);
      check_if("jump", 32'h0000_0100, 32'h0, 32'h8000_000C);
      stall = 1'b1;
      step(); check_if("stall1", 32'h0000_0100, 32'h0, 32'h8000_000C);
      step(); check_if("stall2", 32'h0000_0100, 32'h0, 32'h8000_000C);
      stall = 1'b0;
      step(); check_if("unstall", 32'h0000_0104, 32'hFFFF_FEFF, 32'h0000_0104);

      // branch overrides stall, mode bit kept
      do_jump(32'h0000_0040);
      check("jump40_pc", pc, 32'h0000_0040);
      stall = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h8000_0200;
      #1 check("br_flush", {31'h0, flush_ID2EX}, 32'h1);
      step(); check_if("branch", 32'h0000_0200, 32'h0, 32'h0000_0044);
      stall = 1'b0;

      // branch beats jump
      ex_br_target = 32'h0000_0500; id_jump = 1'b1; id_jump_target = 32'h0000_0300;
      step(); check_if("br_vs_jump", 32'h0000_0500, 32'h0, 32'h0000_0204);
      ex_br_taken = 1'b0; id_jump = 1'b0;
      #1 check("noflush", {31'h0, flush_ID2EX}, 32'h0);

      // irq raised in kernel mode waits for user mode
      do_jump(32'h8000_0010);
      irq = 1'b1;
      step(); check("irq_set_pc", pc, 32'h8000_0014);
      check("irq_set_pend", {31'h0, irq_pending}, 32'h1);
      irq = 1'b0;
      step(); check("irq_wait_pc", pc, 32'h8000_0018);
      check("irq_wait_pend", {31'h0, irq_pending}, 32'h1);
      do_jump(32'h0000_0020);
      check("irq_user_pc", pc, 32'h0000_0020);
      check("irq_user_pend", {31'h0, irq_pending}, 32'h1);
      step(); check_if("irq_entry", 32'h8000_0008, 32'h0, 32'h0000_0024);
      check("irq_entry_out", {31'h0, IF2ID_irq_out}, 32'h1);
      check("irq_entry_pend", {31'h0, irq_pending}, 32'h0);
      step(); check_if("post_irq", 32'h8000_000C, 32'h7FFF_FFF7, 32'h8000_000C);
      check("post_irq_out", {31'h0, IF2ID_irq_out}, 32'h0);

      // illegal opcode
      do_jump(32'h0000_0060);
      id_illop = 1'b1;
      #1 check("illop_flush", {31'h0, flush_ID2EX}, 32'h1);
      step(); check_if("illop", 32'h8000_0004, 32'h0, 32'h0000_0064);
      id_illop = 1'b0;

      // stall blocks irq entry
      do_jump(32'h0000_0070);
      stall = 1'b1; irq = 1'b1;
      step(); check("stirq_pc", pc, 32'h0000_0070);
      check("stirq_pend", {31'h0, irq_pending}, 32'h1);
      irq = 1'b0;
      step(); check("stirq_hold_pc", pc, 32'h0000_0070);
      check("stirq_out", {31'h0, IF2ID_irq_out}, 32'h0);
      stall = 1'b0;
      step(); check_if("stirq_entry", 32'h8000_0008, 32'h0, 32'h0000_0074);
      check("stirq_entry_out", {31'h0, IF2ID_irq_out}, 32'h1);

      // irq held high through entry keeps pending set
      do_jump(32'h0000_0080);
      irq = 1'b1;
      step(); check("hold_pc", pc, 32'h0000_0084);
      step(); check("hold_entry_pc", pc, 32'h8000_0008);
      check("hold_entry_pcout", IF2ID_PC_out, 32'h0000_0088);
      check("hold_entry_pend", {31'h0, irq_pending}, 32'h1);
      irq = 1'b0;

      // asynchronous reset between edges
      #2 reset = 1'b1;
      #1 check("async_pc", pc, 32'h8000_0000);
      check("async_pend", {31'h0, irq_pending}, 32'h0);
      check("async_instr", IF2ID_Instr_out, 32'h0);
      step(); reset = 1'b0;
      step(); check("after_reset_pc", pc, 32'h8000_0004);

      // wrap within low 31 bits, both modes
      do_jump(32'h7FFF_FFFC);
      step(); check_if("wrap_user", 32'h0000_0000, 32'h8000_0003, 32'h0000_0000);
      do_jump(32'hFFFF_FFFC);
      check("jr_verbatim", pc, 32'hFFFF_FFFC);
      step(); check_if("wrap_kern", 32'h8000_0000, 32'h0000_0003, 32'h8000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
